bus_responder: RTL
==================

# bus_responder

Target-side end of the 8080 core's external byte-serial bus. It decodes the four-phase req/ack handshake driven by the CPU's bus interface, assembles the 16-bit address from two address phases, and performs reads and writes on a simple single-cycle-request memory/IO port. It serves as the memory/peripheral model in FPGA bring-up and as the bench-side bus target in simulation.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ready in a data phase; 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- bus_handshake_req  in  1  initiator request; level-held until ack is seen.
- bus_state  in  2  phase code: 0 addr low, 1 addr high, 2 read data, 3 write data.
- bus_io  in  1  1 = I/O space, 0 = memory space.
- bus_data_in  in  8  byte from initiator (address or write data).
- bus_data_out  out  8  read data toward initiator.
- bus_output_enable  out  1  drive enable for bus_data_out.
- bus_handshake_ack  out  1  responder acknowledge.
- mem_addr  out  16  assembled address.
- mem_io  out  1  latched bus_io of the data phase.
- mem_read  out  1  one-cycle read strobe.
- mem_write  out  1  one-cycle write strobe.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid with mem_ready.
- mem_ready  in  1  completes the pending read/write.
- timeout_err  out  1  sticky; set when a data phase times out.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE: when sampled req = 1, capture bus_state, bus_io, bus_data_in.
  - Phase 0: addr[7:0] <= data. Go to ACK.
  - Phase 1: addr[15:8] <= data. Go to ACK.
  - Phase 2: pulse mem_read for one cycle and go to ACCESS.
  - Phase 3: mem_wdata <= data, pulse mem_write for one cycle, and go to ACCESS.
- ACCESS:
  - On mem_ready: for a read, bus_data_out <= mem_rdata and bus_output_enable <= 1. Go to ACK.
  - If TIMEOUT_CYCLES elapse without mem_ready: for a read, bus_data_out <= 8'hFF and oe <= 1. Set timeout_err. Go to ACK.
- ACK: ack = 1 while sampled req = 1. When sampled req = 0: ack <= 0, oe <= 0, go to IDLE.
- The address persists across transactions; a data phase with no prior address phase uses the retained address.
- mem_ready outside ACCESS is ignored.
- The timeout counter is 16-bit, cleared on entry to ACCESS, and saturates.
- timeout_err is cleared only by rst.
- Reset mid-operation: all state returns to reset values in the same edge. Any pending access is abandoned and no strobe is emitted.

## Timing
- Reset values:
  - ack = 0, oe = 0, bus_data_out = 0.
  - mem_addr = 0, mem_io = 0, mem_read = 0, mem_write = 0, mem_wdata = 0.
  - timeout_err = 0, state = IDLE.
- "Sampled req" means the input after the optional synchronizer (S = 2 cycles with the sync compiled in, S = 0 without).
- Address phase: ack rises S+1 cycles after req rises.
- Data phase: the strobe rises S+1 cycles after req rises. If mem_ready is high in cycle k after the strobe (k ≥ 1), ack and oe rise at k+1.
- Release: ack falls S+1 cycles after req falls; oe falls on the same edge.
- bus_data_out is stable for the whole time oe = 1.
- Only one strobe per phase; strobes are never asserted simultaneously.

## Configuration
- BUS_RESPONDER_SYNC_EN defined: bus_handshake_req passes through a two-flop synchronizer (S = 2). bus_state, bus_io and bus_data_in are sampled only when sampled req is seen high; the initiator guarantees they are stable before it raises req.
- Not defined: req is used directly (S = 0). This mode is only valid when initiator and responder share clk.

## Structure
- Shared package bus_pkg holds:
  - phase constants: PH_ADDR_LO = 0, PH_ADDR_HI = 1, PH_READ = 2, PH_WRITE = 3;
  - the FSM state enum;
  - the timeout counter width.
- The CPU-side bus interface also uses bus_pkg.
- One sub-module: bus_resp_sync, a two-flop synchronizer with synchronous active-high reset. It is instantiated only under BUS_RESPONDER_SYNC_EN.

## Test plan
- Memory write: phases 0 (0x34), 1 (0x12), 3 (0xA5) with mem_ready tied 1. Expect one mem_write pulse with mem_addr = 0x1234, mem_wdata = 0xA5, mem_io = 0, and three complete req/ack handshakes.
- I/O read: phases 0 (0x10), 1 (0x00), 2 with bus_io = 1. mem_ready arrives 3 cycles after mem_read with mem_rdata = 0x5A. Expect bus_data_out = 0x5A, oe = 1 and ack rising at the same edge; oe falls with ack after req drops.
- Timeout: a read with mem_ready held 0 and TIMEOUT_CYCLES = 4. Expect ack after 4 cycles, bus_data_out = 0xFF, timeout_err = 1 and remaining 1 through a later good transaction.
- Reset mid-access: assert rst while in ACCESS. Expect ack = 0, oe = 0, no strobes and mem_addr = 0 on the next cycle, followed by a normal transaction succeeding.
- Address reuse: write to 0x2000, then a phase-3 write only with 0x77. Expect mem_addr = 0x2000 on the second strobe.
- Latency: measure req-to-ack for an address phase. Expect 3 cycles with BUS_RESPONDER_SYNC_EN defined and 1 cycle without.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg
//   Shared definitions for the 8080 byte-serial external bus. Both the
//   CPU-side bus interface and the target-side bus_responder import this
//   package so that phase codes and the responder FSM encoding agree.
//
//   Contents:
//     PH_ADDR_LO / PH_ADDR_HI / PH_READ / PH_WRITE  - bus_state phase codes
//     resp_state_e                                  - responder FSM states
//     TMO_CNT_W                                     - data-phase timeout counter width
package bus_pkg;

  localparam logic [1:0] PH_ADDR_LO = 2'd0;
  localparam logic [1:0] PH_ADDR_HI = 2'd1;
  localparam logic [1:0] PH_READ    = 2'd2;
  localparam logic [1:0] PH_WRITE   = 2'd3;

  localparam int TMO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } resp_state_e;

endpackage

// File: rtl/bus_resp_sync.sv
// bus_resp_sync
//   Two-flop synchronizer for the initiator's handshake request when the
//   initiator runs on a different clock than the responder.
//
//   Ports:
//     clk  - responder clock
//     rst  - synchronous active-high reset, clears both flops
//     d_i  - asynchronous input
//     q_o  - synchronized output, two clk cycles behind d_i
module bus_resp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bus_responder.sv
// bus_responder
//   Target end of the 8080 core's byte-serial bus. Decodes the four-phase
//   req/ack handshake, assembles a 16-bit address from two address phases
//   and performs reads/writes on a single-cycle-strobe memory/IO port.
//
//   Build option:
//     BUS_RESPONDER_SYNC_EN - when defined, bus_handshake_req passes through
//                             bus_resp_sync (two cycles extra latency). When
//                             not defined, req is used directly and the
//                             initiator must share clk.
//
//   Ports:
//     clk, rst               - clock, synchronous active-high reset
//     bus_handshake_req      - initiator request, level-held until ack
//     bus_state              - phase: 0 addr lo, 1 addr hi, 2 read, 3 write
//     bus_io                 - 1 = I/O space, 0 = memory space
//     bus_data_in            - address byte or write data
//     bus_data_out           - read data toward initiator
//     bus_output_enable      - drive enable for bus_data_out
//     bus_handshake_ack      - responder acknowledge
//     mem_addr, mem_io       - assembled address, space of the data phase
//     mem_read, mem_write    - one-cycle access strobes
//     mem_wdata              - write data
//     mem_rdata, mem_ready   - read data / completion from the memory port
//     timeout_err            - sticky flag, a data phase ran out of time
module bus_responder
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_handshake_req,
  input  logic [1:0]  bus_state,
  input  logic        bus_io,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_output_enable,
  output logic        bus_handshake_ack,
  output logic [15:0] mem_addr,
  output logic        mem_io,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  // Timeout fires at the end of the ACCESS cycle whose count equals this,
  // so a data phase spends exactly TIMEOUT_CYCLES cycles in ACCESS.
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0] CNT_MAX  = {TMO_CNT_W{1'b1}};
  localparam logic [TMO_CNT_W-1:0] CNT_ONE  = {{(TMO_CNT_W-1){1'b0}}, 1'b1};

  logic reqSampled;

`ifdef BUS_RESPONDER_SYNC_EN
  bus_resp_sync u_reqSync (
    .clk (clk),
    .rst (rst),
    .d_i (bus_handshake_req),
    .q_o (reqSampled)
  );
`else
  assign reqSampled = bus_handshake_req;
`endif

  resp_state_e          state_q, state_d;
  logic [15:0]          addr_q, addr_d;
  logic                 io_q, io_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 rdStrobe_q, rdStrobe_d;
  logic                 wrStrobe_q, wrStrobe_d;
  logic                 isRead_q, isRead_d;
  logic [7:0]           dout_q, dout_d;
  logic                 oe_q, oe_d;
  logic                 err_q, err_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 strobeActive;

  // Register bank; reset abandons any pending access in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      io_q       <= 1'b0;
      wdata_q    <= '0;
      rdStrobe_q <= 1'b0;
      wrStrobe_q <= 1'b0;
      isRead_q   <= 1'b0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      io_q       <= io_d;
      wdata_q    <= wdata_d;
      rdStrobe_q <= rdStrobe_d;
      wrStrobe_q <= wrStrobe_d;
      isRead_q   <= isRead_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // mem_ready is not accepted while the strobe itself is out: completion
  // is expected at the earliest one cycle after the request.
  assign strobeActive = rdStrobe_q | wrStrobe_q;

  // Next-state logic: phase decode in IDLE, wait/timeout in ACCESS,
  // release in ACK. Strobes default low so they last exactly one cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    io_d       = io_q;
    wdata_d    = wdata_q;
    rdStrobe_d = 1'b0;
    wrStrobe_d = 1'b0;
    isRead_d   = isRead_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (reqSampled) begin
          case (bus_state)
            PH_ADDR_LO: begin
              addr_d[7:0] = bus_data_in;
              state_d     = ACK;
            end
            PH_ADDR_HI: begin
              addr_d[15:8] = bus_data_in;
              state_d      = ACK;
            end
            PH_READ: begin
              io_d       = bus_io;
              isRead_d   = 1'b1;
              rdStrobe_d = 1'b1;
              cnt_d      = '0;
              state_d    = ACCESS;
            end
            default: begin
              io_d       = bus_io;
              isRead_d   = 1'b0;
              wdata_d    = bus_data_in;
              wrStrobe_d = 1'b1;
              cnt_d      = '0;
              state_d    = ACCESS;
            end
          endcase
        end
      end
      ACCESS: begin
        if (!strobeActive && mem_ready) begin
          if (isRead_q) begin
            dout_d = mem_rdata;
            oe_d   = 1'b1;
          end
          state_d = ACK;
        end else if (cnt_q >= TMO_LAST) begin
          if (isRead_q) begin
            dout_d = 8'hFF;
            oe_d   = 1'b1;
          end
          err_d   = 1'b1;
          state_d = ACK;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ACK: begin
        if (!reqSampled) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_handshake_ack = (state_q == ACK);
  assign bus_output_enable = oe_q;
  assign bus_data_out      = dout_q;
  assign mem_addr          = addr_q;
  assign mem_io            = io_q;
  assign mem_read          = rdStrobe_q;
  assign mem_write         = wrStrobe_q;
  assign mem_wdata         = wdata_q;
  assign timeout_err       = err_q;

endmodule
